alu_sequencer: RTL

- Multicycle instruction sequencer that drives the ALU (`OP`/`In1`/`In2`) and consumes its `Result`/`Zero_flag`.
- Accepts one decoded-bus MIPS instruction at a time over a valid/ready handshake.
- Reads the register file, generates the 5-bit ALU operation code, and sequences memory access for LW/SW.
- Issues register writeback and PC redirects.
- Sits between the fetch stage and the ALU, register file and data memory.

---
 rtl/alu_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multicycle MIPS sequencer in front of the ALU, register
// file and data memory. One instruction in flight; IDLE/DECODE/EXEC/MEM/WB.
// Writeback/redirect strobes are registered out of WB, so they are visible
// in the first IDLE cycle, alongside instr_ready.
module alu_sequencer #(
  parameter int RA_REG = 31,
  parameter int PC_W   = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc_in,
  output logic [4:0]      rs_addr,
  output logic [4:0]      rt_addr,
  input  logic [31:0]     rs_data,
  input  logic [31:0]     rt_data,
  output logic [4:0]      alu_op,
  output logic [31:0]     alu_in1,
  output logic [31:0]     alu_in2,
  input  logic [31:0]     alu_result,
  input  logic            alu_zero,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [31:0]     wb_data,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_target,
  output logic            illegal
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [3:0] {C_RD, C_RT, C_LW, C_SW, C_BR, C_JR, C_J, C_JAL, C_ILL} cls_t;

  state_t          state, state_d;
  cls_t            cls_q, cls_d;
  logic [31:0]     instr_q, in1_q, in2_q, st_q, res_q, ld_q, in1_d, in2_d;
  logic [PC_W-1:0] pc_q, pcp4, br_tgt, j_tgt;
  logic [4:0]      op_q, op_d;
  logic            zero_q;

  logic [5:0]  opc, fn;
  logic [15:0] imm;
  logic [31:0] sext, zext, shamt;

  assign opc   = instr_q[31:26];
  assign fn    = instr_q[5:0];
  assign imm   = instr_q[15:0];
  assign sext  = {{16{imm[15]}}, imm};
  assign zext  = {16'd0, imm};
  assign shamt = {27'd0, instr_q[10:6]};

  assign pcp4   = pc_q + PC_W'(4);
  assign br_tgt = pcp4 + {{(PC_W-18){imm[15]}}, imm, 2'b00};
  assign j_tgt  = {pcp4[PC_W-1:28], instr_q[25:0], 2'b00};

  assign rs_addr = instr_q[25:21];
  assign rt_addr = instr_q[20:16];
  assign alu_op  = op_q;
  assign alu_in1 = in1_q;
  assign alu_in2 = in2_q;

  // Decode: ALU op, operand routing and instruction class from the held word
  always_comb begin
    op_d  = 5'b01111;
    in1_d = rs_data;
    in2_d = rt_data;
    cls_d = C_ILL;
    case (opc)
      6'h00: begin
        cls_d = C_RD;
        case (fn)
          6'h24: op_d = 5'b00000;
          6'h25: op_d = 5'b00001;
          6'h20, 6'h21: op_d = 5'b00010;
          6'h26: op_d = 5'b00011;
          6'h27: op_d = 5'b00100;
          6'h2A: op_d = 5'b00101;
          6'h22, 6'h23: op_d = 5'b00110;
          6'h2B: op_d = 5'b00111;
          6'h00: begin op_d = 5'b01000; in1_d = rt_data; in2_d = shamt; end
          6'h02: begin op_d = 5'b01001; in1_d = rt_data; in2_d = shamt; end
          6'h03: begin op_d = 5'b01010; in1_d = rt_data; in2_d = shamt; end
          6'h04: begin op_d = 5'b01011; in1_d = rt_data; in2_d = rs_data; end
          6'h06: begin op_d = 5'b01100; in1_d = rt_data; in2_d = rs_data; end
          6'h07: begin op_d = 5'b01101; in1_d = rt_data; in2_d = rs_data; end
          6'h08: begin op_d = 5'b01110; cls_d = C_JR; end
          default: cls_d = C_ILL;
        endcase
      end
      6'h08: begin op_d = 5'b10000; in2_d = sext; cls_d = C_RT; end
      6'h0C: begin op_d = 5'b10001; in2_d = zext; cls_d = C_RT; end
      6'h0D: begin op_d = 5'b10010; in2_d = zext; cls_d = C_RT; end
      6'h0E: begin op_d = 5'b10011; in2_d = zext; cls_d = C_RT; end
      6'h04: begin op_d = 5'b10100; cls_d = C_BR; end
      6'h05: begin op_d = 5'b10101; cls_d = C_BR; end
      6'h0A: begin op_d = 5'b10111; in2_d = sext; cls_d = C_RT; end
      6'h0B: begin op_d = 5'b11000; in2_d = sext; cls_d = C_RT; end
      6'h0F: begin op_d = 5'b11001; in2_d = zext; cls_d = C_RT; end
      6'h23: begin op_d = 5'b00010; in2_d = sext; cls_d = C_LW; end
      6'h2B: begin op_d = 5'b00010; in2_d = sext; cls_d = C_SW; end
      6'h02: cls_d = C_J;
      6'h03: cls_d = C_JAL;
      default: cls_d = C_ILL;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next state plus handshake and memory request outputs
  always_comb begin
    state_d     = state;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    case (state)
      S_IDLE: begin
        instr_ready = reset_n;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (cls_q == C_SW);
        mem_addr  = res_q;
        mem_wdata = st_q;
        if (mem_ack) state_d = S_WB;
      end
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath capture per state; strobes are single-cycle, set only from WB
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= '0; pc_q <= '0; cls_q <= C_ILL;
      op_q <= '0; in1_q <= '0; in2_q <= '0; st_q <= '0;
      res_q <= '0; zero_q <= 1'b0; ld_q <= '0;
      wb_en <= 1'b0; wb_addr <= '0; wb_data <= '0;
      pc_load <= 1'b0; pc_target <= '0; illegal <= 1'b0;
    end else begin
      wb_en   <= 1'b0;
      pc_load <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid) begin instr_q <= instr; pc_q <= pc_in; end
        S_DECODE: begin
          op_q <= op_d; in1_q <= in1_d; in2_q <= in2_d; cls_q <= cls_d; st_q <= rt_data;
        end
        S_EXEC: begin res_q <= alu_result; zero_q <= alu_zero; end
        S_MEM:  if (mem_ack) ld_q <= mem_rdata;
        S_WB: begin
          case (cls_q)
            C_RD: begin
              wb_en <= (instr_q[15:11] != 5'd0); wb_addr <= instr_q[15:11]; wb_data <= res_q;
            end
            C_RT: begin
              wb_en <= (instr_q[20:16] != 5'd0); wb_addr <= instr_q[20:16]; wb_data <= res_q;
            end
            C_LW: begin
              wb_en <= (instr_q[20:16] != 5'd0); wb_addr <= instr_q[20:16]; wb_data <= ld_q;
            end
            C_BR: begin pc_load <= !zero_q; pc_target <= br_tgt; end
            C_JR: begin pc_load <= 1'b1; pc_target <= res_q[PC_W-1:0]; end
            C_J:  begin pc_load <= 1'b1; pc_target <= j_tgt; end
            C_JAL: begin
              pc_load <= 1'b1; pc_target <= j_tgt;
              wb_en <= (RA_REG != 0); wb_addr <= 5'(RA_REG); wb_data <= 32'(pc_q + PC_W'(8));
            end
            C_ILL:   illegal <= 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule
